// File: rtl/alu_pipe.sv
// Sequential ALU with valid/ready on both sides. All ops except MUL finish in one cycle;
// MUL runs a shift-add over WIDTH cycles. Results are 2*WIDTH wide and registered.
module alu_pipe #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [WIDTH-1:0]   d0_in,
  input  logic [WIDTH-1:0]   d1_in,
  input  logic [2:0]         sel_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [2*WIDTH-1:0] res_out,
  output logic               gt_out,
  output logic               eq_out,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [1:0]         dbg_state
);

  localparam int RW = 2 * WIDTH;
  localparam int SW = $clog2(RW);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [RW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic [RW-1:0]    a_ext;
  logic [RW-1:0]    b_ext;
  logic [RW-1:0]    op_res;
  logic [RW-1:0]    pp;
  logic [RW-1:0]    acc_next;
  logic [SW-1:0]    shamt;
  logic             accept;

  function automatic logic is_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED_CMP) return $signed(a) > $signed(b);
    else return a > b;
  endfunction

  // Handshake protocol: a transfer happens on a rising edge where valid and ready are both
  // high on the same side. valid_out stays high until the consumer takes the result; a new
  // operation can be accepted in the very cycle the previous result is taken.
  assign ready_out = rst_n_in && ((state == IDLE) || ((state == DONE) && ready_in));
  assign accept    = valid_in && ready_out;
  assign dbg_state = state;

  always_comb begin
    a_ext = {{WIDTH{1'b0}}, d0_in};
    b_ext = {{WIDTH{1'b0}}, d1_in};
    shamt = d1_in[SW-1:0];
    case (sel_in)
      3'd0:    op_res = a_ext + b_ext;
      3'd1:    op_res = a_ext - b_ext;
      3'd2:    op_res = a_ext & b_ext;
      3'd3:    op_res = a_ext | b_ext;
      3'd4:    op_res = a_ext ^ b_ext;
      3'd6:    op_res = a_ext << shamt;
      3'd7:    op_res = a_ext >> shamt;
      default: op_res = '0;
    endcase
  end

  // One partial product per BUSY cycle, selected by multiplier bit cnt.
  always_comb begin
    pp       = b_q[cnt] ? ({{WIDTH{1'b0}}, a_q} << cnt) : '0;
    acc_next = acc + pp;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      res_out   <= '0;
      gt_out    <= 1'b0;
      eq_out    <= 1'b0;
      valid_out <= 1'b0;
    end else if (state == BUSY) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        res_out   <= acc_next;
        gt_out    <= is_gt(a_q, b_q);
        eq_out    <= (a_q == b_q);
        valid_out <= 1'b1;
        state     <= DONE;
      end
    end else if (accept) begin
      a_q <= d0_in;
      b_q <= d1_in;
      if (sel_in == 3'd5) begin
        acc       <= '0;
        cnt       <= '0;
        valid_out <= 1'b0;
        state     <= BUSY;
      end else begin
        res_out   <= op_res;
        gt_out    <= is_gt(d0_in, d1_in);
        eq_out    <= (d0_in == d1_in);
        valid_out <= 1'b1;
        state     <= DONE;
      end
    end else if ((state == DONE) && ready_in) begin
      valid_out <= 1'b0;
      state     <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8); a second instance with SIGNED_CMP=1 shares the inputs.
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic [7:0]  d0;
  logic [7:0]  d1;
  logic [2:0]  sel;
  logic        valid_in;
  logic        ready_in;

  logic        rdy_u, gt_u, eq_u, vld_u;
  logic [15:0] res_u;
  logic [1:0]  st_u;
  logic        rdy_s, gt_s, eq_s, vld_s;
  logic [15:0] res_s;
  logic [1:0]  st_s;

  int n_pass  = 0;
  int n_total = 0;

  alu_pipe #(.WIDTH(8), .SIGNED_CMP(1'b0)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .d0_in(d0), .d1_in(d1), .sel_in(sel),
    .valid_in(valid_in), .ready_out(rdy_u), .res_out(res_u), .gt_out(gt_u),
    .eq_out(eq_u), .valid_out(vld_u), .ready_in(ready_in), .dbg_state(st_u)
  );

  alu_pipe #(.WIDTH(8), .SIGNED_CMP(1'b1)) dut_s (
    .clk_in(clk), .rst_n_in(rst_n), .d0_in(d0), .d1_in(d1), .sel_in(sel),
    .valid_in(valid_in), .ready_out(rdy_s), .res_out(res_s), .gt_out(gt_s),
    .eq_out(eq_s), .valid_out(vld_s), .ready_in(ready_in), .dbg_state(st_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // single non-MUL op with ready_in=1; checks the result one cycle after accept
  task automatic op1(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] s, input logic [15:0] exp_res);
    d0 = a; d1 = b; sel = s; valid_in = 1'b1;
    chk({tag, "_rdy"}, 32'(rdy_u), 32'd1);
    @(negedge clk);
    valid_in = 1'b0;
    chk({tag, "_vld"}, 32'(vld_u), 32'd1);
    chk({tag, "_res"}, 32'(res_u), 32'(exp_res));
  endtask

  // MUL: busy with ready_out=0 and no valid for 8 sampled cycles, result on the 9th
  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_res);
    d0 = a; d1 = b; sel = 3'd5; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_busy_rdy"}, 32'(rdy_u), 32'd0);
      chk({tag, "_busy_vld"}, 32'(vld_u), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_vld"}, 32'(vld_u), 32'd1);
    chk({tag, "_res"}, 32'(res_u), 32'(exp_res));
    @(negedge clk);
  endtask

  logic [15:0] exp_alu [5];

  initial begin
    exp_alu = '{16'd57, 16'hFFDF, 16'd12, 16'd45, 16'd33};
    rst_n = 1'b0; d0 = '0; d1 = '0; sel = '0; valid_in = 1'b0; ready_in = 1'b1;

    // reset state and release
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(rdy_u), 32'd0);
    chk("rst_vld", 32'(vld_u), 32'd0);
    chk("rst_res", 32'(res_u), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_rdy", 32'(rdy_u), 32'd1);
    chk("rel_vld", 32'(vld_u), 32'd0);
    chk("rel_res", 32'(res_u), 32'd0);
    chk("rel_gt",  32'(gt_u),  32'd0);
    chk("rel_eq",  32'(eq_u),  32'd0);
    @(negedge clk);

    // ops 0-4 streamed back to back, one per cycle
    for (int i = 0; i < 5; i++) begin
      d0 = 8'd12; d1 = 8'd45; sel = 3'(i); valid_in = 1'b1;
      chk("stream_rdy", 32'(rdy_u), 32'd1);
      @(negedge clk);
      chk("stream_vld", 32'(vld_u), 32'd1);
      chk("stream_res", 32'(res_u), 32'(exp_alu[i]));
      chk("stream_gt",  32'(gt_u),  32'd0);
      chk("stream_eq",  32'(eq_u),  32'd0);
    end
    valid_in = 1'b0;
    @(negedge clk);
    chk("idle_vld",  32'(vld_u), 32'd0);
    chk("idle_hold", 32'(res_u), 32'd33);

    // multiply
    run_mul("mul_12x45", 8'd12, 8'd45, 16'd540);
    run_mul("mul_ffxff", 8'hFF, 8'hFF, 16'd65025);
    run_mul("mul_bzero", 8'd200, 8'd0, 16'd0);

    // shifts and compares
    op1("shl", 8'd1, 8'd15, 3'd6, 16'h8000);
    @(negedge clk);
    op1("shr", 8'd200, 8'd3, 3'd7, 16'd25);
    @(negedge clk);
    op1("cmp_ff", 8'hFF, 8'd1, 3'd0, 16'h0100);
    chk("gt_unsigned", 32'(gt_u), 32'd1);
    chk("gt_signed",   32'(gt_s), 32'd0);
    chk("eq_ff",       32'(eq_u), 32'd0);
    @(negedge clk);
    op1("cmp_77", 8'd77, 8'd77, 3'd4, 16'd0);
    chk("eq_77", 32'(eq_u), 32'd1);
    chk("gt_77", 32'(gt_u), 32'd0);
    @(negedge clk);

    // backpressure: result held 5 cycles, pending op not accepted
    ready_in = 1'b0;
    d0 = 8'd100; d1 = 8'd200; sel = 3'd0; valid_in = 1'b1;
    @(negedge clk);
    d0 = 8'd3; d1 = 8'd5; sel = 3'd4;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 32'(vld_u), 32'd1);
      chk("bp_res", 32'(res_u), 32'd300);
      chk("bp_rdy", 32'(rdy_u), 32'd0);
      @(negedge clk);
    end
    chk("bp_res_end", 32'(res_u), 32'd300);
    ready_in = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(rdy_u), 32'd1);
    @(negedge clk);
    valid_in = 1'b0;
    chk("bp_next_vld", 32'(vld_u), 32'd1);
    chk("bp_next_res", 32'(res_u), 32'd6);
    @(negedge clk);
    chk("bp_done_vld", 32'(vld_u), 32'd0);

    // reset in the middle of a multiply
    d0 = 8'd12; d1 = 8'd45; sel = 3'd5; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_res", 32'(res_u), 32'd0);
    chk("abort_vld", 32'(vld_u), 32'd0);
    chk("abort_rdy", 32'(rdy_u), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_vld", 32'(vld_u), 32'd0);
    end
    op1("post_add", 8'd7, 8'd9, 3'd0, 16'd16);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
